// File: rtl/pio_echo_responder.sv
// FPGA-side responder for the HPS<->FPGA PIO latency link: echoes a toggled request word,
// stamps it with a free-running cycle count and times the ARM's acknowledge.
module pio_echo_responder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RESP_DELAY     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] req_in,
  input  logic [31:0] ack_in,
  output logic [31:0] rsp_out,
  output logic [31:0] ts_out,
  output logic [31:0] rtt_out,
  output logic [31:0] status_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PUBLISH,
    S_WAIT_ACK
  } state_t;

  localparam logic [31:0] DELAY_LOAD   = 32'(RESP_DELAY);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] req_sync_q [SYNC_STAGES];
  logic [31:0] ack_sync_q [SYNC_STAGES];
  logic [31:0] req_s, ack_s;

  state_t      state_q, state_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] dly_cnt_q, dly_cnt_d;
  logic [31:0] rtt_cnt_q, rtt_cnt_d;
  logic        tog_q, tog_d;
  logic [30:0] seq_q, seq_d;
  logic [31:0] rsp_q, rsp_d;
  logic [31:0] ts_q, ts_d;
  logic [31:0] rtt_q, rtt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;
  logic        mismatch_q, mismatch_d;
  logic        prev_req_q, prev_req_d;
  logic        prev_ack_q, prev_ack_d;

  logic req_evt, ack_evt, ack_done, flag_clr;
  logic set_timeout, set_overrun, set_mismatch;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= '0;
        ack_sync_q[i] <= '0;
      end
    end else begin
      req_sync_q[0] <= req_in;
      ack_sync_q[0] <= ack_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= req_sync_q[i-1];
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  assign req_evt  = req_s[31] ^ prev_req_q;
  assign ack_evt  = ack_s[31] ^ prev_ack_q;
  assign ack_done = ack_evt && (ack_s[31] == rsp_q[31]);
  assign flag_clr = ack_s[30];

  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q + 32'd1;
    dly_cnt_d    = dly_cnt_q;
    rtt_cnt_d    = rtt_cnt_q;
    tog_d        = tog_q;
    seq_d        = seq_q;
    rsp_d        = rsp_q;
    ts_d         = ts_q;
    rtt_d        = rtt_q;
    cnt_d        = cnt_q;
    prev_req_d   = req_s[31];
    prev_ack_d   = ack_s[31];
    set_timeout  = 1'b0;
    set_mismatch = 1'b0;
    // Any request event outside IDLE is dropped, including one coinciding with WAIT_ACK exit.
    set_overrun  = req_evt && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (req_evt) begin
          ts_d      = cyc_cnt_q;
          tog_d     = req_s[31];
          seq_d     = req_s[30:0];
          dly_cnt_d = DELAY_LOAD;
          state_d   = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_cnt_q == '0) begin
          state_d = S_PUBLISH;
        end else begin
          dly_cnt_d = dly_cnt_q - 32'd1;
        end
      end
      S_PUBLISH: begin
        rsp_d     = {tog_q, seq_q};
        rtt_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack landing on the timeout cycle still completes the handshake.
        if (ack_done) begin
          rtt_d        = rtt_cnt_q;
          cnt_d        = cnt_q + 16'd1;
          set_mismatch = (ack_s[29:0] != seq_q[29:0]);
          state_d      = S_IDLE;
        end else if (rtt_cnt_q == TIMEOUT_LAST) begin
          set_timeout = 1'b1;
          rtt_d       = '1;
          state_d     = S_IDLE;
        end else if (rtt_cnt_q != '1) begin
          rtt_cnt_d = rtt_cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    timeout_d  = set_timeout  | (timeout_q  & ~flag_clr);
    overrun_d  = set_overrun  | (overrun_q  & ~flag_clr);
    mismatch_d = set_mismatch | (mismatch_q & ~flag_clr);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_IDLE;
      cyc_cnt_q  <= '0;
      dly_cnt_q  <= '0;
      rtt_cnt_q  <= '0;
      tog_q      <= 1'b0;
      seq_q      <= '0;
      rsp_q      <= '0;
      ts_q       <= '0;
      rtt_q      <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      mismatch_q <= 1'b0;
      prev_req_q <= 1'b0;
      prev_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      rtt_cnt_q  <= rtt_cnt_d;
      tog_q      <= tog_d;
      seq_q      <= seq_d;
      rsp_q      <= rsp_d;
      ts_q       <= ts_d;
      rtt_q      <= rtt_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
      mismatch_q <= mismatch_d;
      prev_req_q <= prev_req_d;
      prev_ack_q <= prev_ack_d;
    end
  end

  assign rsp_out    = rsp_q;
  assign ts_out     = ts_q;
  assign rtt_out    = rtt_q;
  assign status_out = {(state_q != S_IDLE), timeout_q, overrun_q, mismatch_q, 12'h000, cnt_q};

endmodule

// File: tb/tb_pio_echo_responder.sv
// Scoreboard bench for pio_echo_responder: every output change is matched against a queued
// snapshot (outputs plus the cycle it should appear on).
module tb_pio_echo_responder;

  logic        clk = 1'b0;
  logic        rstn  [2];
  logic [31:0] req   [2];
  logic [31:0] ack   [2];
  logic [31:0] rsp_o [2];
  logic [31:0] ts_o  [2];
  logic [31:0] rtt_o [2];
  logic [31:0] st_o  [2];
  int          ec    [2];

  always #5 clk = ~clk;

  pio_echo_responder #(.SYNC_STAGES(2), .RESP_DELAY(0), .TIMEOUT_CYCLES(1000)) u_dut0 (
    .clk_clk(clk), .reset_reset_n(rstn[0]), .req_in(req[0]), .ack_in(ack[0]),
    .rsp_out(rsp_o[0]), .ts_out(ts_o[0]), .rtt_out(rtt_o[0]), .status_out(st_o[0])
  );

  pio_echo_responder #(.SYNC_STAGES(2), .RESP_DELAY(7), .TIMEOUT_CYCLES(1000)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rstn[1]), .req_in(req[1]), .ack_in(ack[1]),
    .rsp_out(rsp_o[1]), .ts_out(ts_o[1]), .rtt_out(rtt_o[1]), .status_out(st_o[1])
  );

  // Reference cycle counter per DUT: value after posedge k equals k since reset release.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) ec[d] <= rstn[d] ? ec[d] + 1 : 0;
  end

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] rsp;
    logic [31:0] ts;
    logic [31:0] rtt;
    logic [31:0] st;
  } exp_t;

  exp_t  expq  [$];
  string nameq [$];
  int    checks   = 0;
  int    failures = 0;

  logic [31:0] m_rsp, m_ts, m_rtt, m_st;

  function automatic logic [31:0] mk_st(input logic b, input logic t, input logic o,
                                        input logic m, input int cnt);
    logic [15:0] c;
    c = 16'(cnt);
    return {b, t, o, m, 12'h000, c};
  endfunction

  task automatic push(input int d, input int cyc, input string nm);
    exp_t e;
    e.dut = d; e.cyc = cyc; e.rsp = m_rsp; e.ts = m_ts; e.rtt = m_rtt; e.st = m_st;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any change of a DUT's output set must match the next queued snapshot.
  logic [127:0] prev [2];
  bit           seen [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [127:0] snap;
      snap = {rsp_o[d], ts_o[d], rtt_o[d], st_o[d]};
      if (!seen[d] || snap !== prev[d]) begin
        exp_t  e;
        string nm;
        seen[d] = 1'b1;
        prev[d] = snap;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change dut%0d: got rsp=0x%08h ts=0x%08h rtt=0x%08h st=0x%08h expected no change",
                   d, rsp_o[d], ts_o[d], rtt_o[d], st_o[d]);
        end else begin
          e  = expq.pop_front();
          nm = nameq.pop_front();
          chk({nm, "_dut"}, 32'(d), 32'(e.dut));
          if (e.cyc >= 0) chk({nm, "_cycle"}, 32'(ec[d]), 32'(e.cyc));
          chk({nm, "_rsp"}, rsp_o[d], e.rsp);
          chk({nm, "_ts"}, ts_o[d], e.ts);
          chk({nm, "_rtt"}, rtt_o[d], e.rtt);
          chk({nm, "_status"}, st_o[d], e.st);
        end
      end
    end
  end

  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req[d] = '0; ack[d] = '0;
    end
    m_rsp = '0; m_ts = '0; m_rtt = '0; m_st = '0;
    push(0, -1, "reset0");
    push(1, -1, "reset1");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn[0] = 1'b1;
    tick(4);

    // Request toggle 0->1, seq 5: detect after 3 edges, publish after 5.
    k = ec[0]; req[0] = 32'h8000_0005;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 0, 0, 0); push(0, k + 3, "t1_detect");
    m_rsp = 32'h8000_0005; push(0, k + 5, "t1_publish");
    tick(5);

    // Ack 100 cycles after publish: rtt = 100 + SYNC_STAGES.
    tick(100);
    k = ec[0]; ack[0] = 32'h8000_0005;
    m_rtt = 32'd102; m_st = mk_st(0, 0, 0, 0, 1); push(0, k + 3, "t2_ack");
    tick(10);

    // No ack: timeout 1000 cycles after publish, then clear with ack[30] for 3 cycles.
    k = ec[0]; req[0] = 32'h0000_000A;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 0, 0, 1); push(0, k + 3, "t3_detect");
    m_rsp = 32'h0000_000A; push(0, k + 5, "t3_publish");
    m_rtt = 32'hFFFF_FFFF; m_st = mk_st(0, 1, 0, 0, 1); push(0, k + 1005, "t3_timeout");
    tick(1010);
    k = ec[0]; ack[0] = 32'hC000_0005;
    m_st = mk_st(0, 0, 0, 0, 1); push(0, k + 3, "t3_clear");
    tick(3);
    ack[0] = 32'h0000_0005;  // ack toggle while IDLE: must be ignored
    tick(10);

    // Overrun: second toggle during WAIT_ACK is dropped; echo and ack proceed.
    k = ec[0]; req[0] = 32'h8000_0005;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 0, 0, 1); push(0, k + 3, "t4_detect");
    m_rsp = 32'h8000_0005; push(0, k + 5, "t4_publish");
    tick(10);
    req[0] = 32'h0000_0006;
    m_st = mk_st(1, 0, 1, 0, 1); push(0, k + 13, "t4_overrun");
    tick(10);
    ack[0] = 32'h8000_0005;
    m_rtt = 32'd17; m_st = mk_st(0, 0, 1, 0, 2); push(0, k + 23, "t4_ack");
    tick(10);
    k = ec[0]; req[0] = 32'h8000_0007;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 1, 0, 2); push(0, k + 3, "t4_accept");
    m_rsp = 32'h8000_0007; push(0, k + 5, "t4_accept_pub");

    // Wrong-phase ack toggle ignored, then ack with seq 9 vs 7: mismatch, still completes.
    tick(7);
    ack[0] = 32'h0000_0009;
    tick(5);
    ack[0] = 32'h8000_0009;
    m_rtt = 32'd9; m_st = mk_st(0, 0, 1, 1, 3); push(0, k + 15, "t5_mismatch");
    tick(10);
    k = ec[0]; ack[0] = 32'hC000_0009;
    m_st = mk_st(0, 0, 0, 0, 3); push(0, k + 3, "t5_clear");
    tick(3);
    ack[0] = 32'h8000_0009;
    tick(5);

    // RESP_DELAY=7 instance: publish at SYNC_STAGES+10, then reset during WAIT_ACK.
    @(negedge clk);
    rstn[1] = 1'b1;
    tick(3);
    k = ec[1]; req[1] = 32'h8000_0003;
    m_rsp = '0; m_rtt = '0;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 0, 0, 0); push(1, k + 3, "t6_detect");
    m_rsp = 32'h8000_0003; push(1, k + 12, "t6_publish");
    tick(32);
    m_rsp = '0; m_ts = '0; m_rtt = '0; m_st = '0; push(1, -1, "t6_reset");
    rstn[1] = 1'b0; req[1] = '0; ack[1] = '0;
    tick(3);
    @(negedge clk);
    rstn[1] = 1'b1;
    tick(20);
    k = ec[1]; req[1] = 32'h8000_0004;
    m_ts = 32'(k + 2); m_st = mk_st(1, 0, 0, 0, 0); push(1, k + 3, "t6_after_detect");
    m_rsp = 32'h8000_0004; push(1, k + 12, "t6_after_publish");
    tick(20);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got %0d outstanding expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
